// File: rtl/imm_gen_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pkg
//   Shared definitions for the decode-stage immediate generator: the format
//   code carried on out_fmt and the RV base opcodes the decoder recognises.
// ---------------------------------------------------------------------------
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// ---------------------------------------------------------------------------
// imm_decode_comb
//   Pure combinational decode of one instruction: format classification,
//   sign-extended immediate and PC-relative target for branches/JAL.
// Ports
//   inst     in  32    instruction word
//   pc       in  XLEN  PC of inst
//   imm      out XLEN  sign-extended immediate (0 for R-type / illegal)
//   fmt      out 3     format code (imm_gen_pkg::fmt_e)
//   target   out XLEN  pc + imm for B/J formats, else 0
//   illegal  out 1     opcode not recognised
// ---------------------------------------------------------------------------
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BYTE_OFFSETS = 1
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    fmt_e                   fmt_sel;
    logic [31:0]            raw32;
    logic signed [XLEN-1:0] imm_sx;
    logic                   is_pc_rel;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        fmt_sel = FMT_ILL;
        raw32   = '0;
        case (inst[6:0])
            OP_REG: fmt_sel = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt_sel = FMT_I;
                raw32   = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                fmt_sel = FMT_S;
                raw32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt_sel = FMT_B;
                raw32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_sel = FMT_U;
                raw32   = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_sel = FMT_J;
                raw32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: fmt_sel = FMT_ILL;
        endcase

        is_pc_rel = (fmt_sel == FMT_B) || (fmt_sel == FMT_J);

        // Every 32-bit pattern above already carries inst[31] in bit 31, so a
        // signed widening gives the XLEN=64 extension for free.
        imm_sx = XLEN'($signed(raw32));
        // Legacy halfword-unit offsets: drop the implicit zero LSB, keep the sign.
        if (BYTE_OFFSETS == 0 && is_pc_rel) begin
            imm_sx = imm_sx >>> 1;
        end

        imm     = imm_sx;
        fmt     = fmt_sel;
        illegal = (fmt_sel == FMT_ILL);
        target  = is_pc_rel ? (pc + imm) : '0;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered, valid/ready immediate generator between fetch and execute.
//   One-cycle latency, full throughput: a main output register backed by a
//   one-entry skid buffer so in_ready is a flop (no comb path from out_ready).
// Ports
//   clk, rst_n         clock / asynchronous active-low reset
//   flush              drop output + skid, discard this cycle's input
//   in_valid/in_ready  upstream handshake
//   in_inst, in_pc     instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_imm, out_fmt, out_target, out_illegal  decoded result
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BYTE_OFFSETS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // Payload layout: {imm, target, fmt, illegal}
    localparam int PW = 2 * XLEN + 4;

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [PW-1:0]   dec_payload;

    imm_decode_comb #(
        .XLEN         (XLEN),
        .BYTE_OFFSETS (BYTE_OFFSETS)
    ) u_decode (
        .inst    (in_inst),
        .pc      (in_pc),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    assign dec_payload = {dec_imm, dec_target, dec_fmt, dec_illegal};

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] skid_data_q, skid_data_d;
    logic          accept;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Flush wins over out_ready: nothing is emitted, nothing is kept.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees this cycle. The skid is older than any new
            // input (and in_ready is low while it is full), so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = dec_payload;
                end
            end
        end else if (accept) begin
            // Output stalled: park the new entry in the skid.
            skid_valid_d = 1'b1;
            skid_data_d  = dec_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: data registers are reset too, so out_* read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_imm, out_target, out_fmt, out_illegal} = out_data_q;

endmodule
